ps2_keyboard_rx: RTL
====================

# ps2_keyboard_rx

PS/2 keyboard receiver: samples the externally clocked PS/2 serial line and checks each frame. Valid scan-code bytes are queued in a small FIFO and presented on a ready/valid interface. It is the input side of the board I/O subsystem, the counterpart of the seven-segment display driver. Downstream logic consumes scan codes, e.g. for display or CPU MMIO.

## Interface
Parameters:
- FIFO_DEPTH, 8: scan-code entries buffered; power of two, ≥2.
- TIMEOUT_CYCLES, 5000: max `clk` cycles between PS/2 falling edges inside one frame.

Ports (clock and reset first):
- clk  in  1  system clock; sole clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- ready_i  in  1  consumer accepts `data_o` this cycle.
- clr_i  in  1  clears `overflow_o`.
- data_o  out  8  scan code at FIFO head; 0 when empty.
- valid_o  out  1  FIFO non-empty.
- frame_err_o  out  1  one-cycle pulse on a rejected frame.
- overflow_o  out  1  sticky: a good frame was dropped because the FIFO was full.

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A third register on the synced clock gives `fall = prev & ~cur`.
- Frame: 11 bits sampled on `fall`: start (0), d0..d7 LSB-first, odd parity, stop (1).
- Receiver FSM states:
  - IDLE: wait for `fall`. If synced data is 0, capture the start bit and go to RECV with bit_cnt=1. Otherwise stay in IDLE with no error.
  - RECV: shift data bits into shreg[7:0] and the parity bit into par. Increment bit_cnt on each `fall`. When bit_cnt reaches 10 and `fall` occurs, sample stop and go to CHECK.
  - CHECK: lasts one cycle. The frame is good iff stop==1 and ^{shreg,par}==1. Good: push shreg. Bad: pulse `frame_err_o`, no push. Return to IDLE.
- Timeout: the idle counter resets on every `fall` and counts only in RECV. At TIMEOUT_CYCLES it discards the partial frame and returns to IDLE. No error pulse, no push.
- FIFO rules:
  - Pop when valid_o & ready_i.
  - Push accepted when not full, or when full with a pop in the same cycle.
  - A good frame that arrives while full with no pop is dropped and sets `overflow_o`.
  - Ordering is strict FIFO.
- `overflow_o`: `clr_i` clears it. A set and a clear in the same cycle leave it set.
- Reset (asynchronous, mid-frame included): FSM to IDLE, bit_cnt/shreg/timeout cleared, FIFO empty. Outputs: data_o=0, valid_o=0, frame_err_o=0, overflow_o=0. Synchronizer flops reset to 1, the PS/2 idle level, so no spurious `fall` occurs.

## Timing
- `fall` is asserted 3 `clk` cycles after the PS/2 clock pin falls.
- CHECK is the cycle after the stop-bit `fall`. The push lands at the end of CHECK, so `valid_o` and `data_o` update in the next cycle. Total: stop-bit pin edge to valid_o = 5 cycles.
- `data_o`/`valid_o` come combinationally from FIFO state registers, with no extra output stage. A pop updates them on the next cycle.
- `frame_err_o` is registered and high for exactly one cycle, aligned with the would-be push cycle.
- Requirement: `clk` ≥ 8× the PS/2 clock rate; 10–16.7 kHz is typical.

## Structure
- Package `ps2_pkg`:
  - FSM state enum {IDLE, RECV, CHECK}.
  - `PS2_FRAME_BITS=11`.
  - Bit-index constants for start, parity and stop.
- Sub-module `ps2_fifo`: synchronous FIFO, parameterized by depth and width. Ports: push/pop/full/empty/head. It has no knowledge of PS/2.
- Synchronizer and edge detect stay inline in the top module.

## Test plan
- Send 0x1C (parity 0, stop 1) at 12.5 kHz with ready_i=1 → valid_o high 1 cycle with data_o=0x1C 5 cycles after the stop edge; frame_err_o stays 0.
- Send 0x1C with parity 1 → frame_err_o one-cycle pulse; valid_o stays 0. Then send 0xF0 → accepted normally.
- With ready_i=0, send 9 good frames 0x01..0x09 → overflow_o=1 after the 9th. Then raise ready_i → pops return 0x01..0x08 in order, then valid_o=0. Pulse clr_i → overflow_o=0.
- Send start + 4 data bits, stall the PS/2 clock for TIMEOUT_CYCLES+10 → FSM back in IDLE, no error. A full 0x5A frame that follows is received correctly.
- Assert rst_n=0 for 2 cycles mid-frame with 3 entries queued → all outputs 0 immediately. The next full 0x29 frame is received as the only entry.
- Fill the FIFO to depth 8, hold ready_i=1, and complete frame 0x33 on the same cycle as a pop → push accepted, overflow_o=0, and 0x33 eventually read last.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and constants for the PS/2 keyboard receiver.
//   - rx_state_e     : receiver FSM states
//   - PS2_FRAME_BITS : bits per PS/2 frame (start, 8 data, parity, stop)
//   - *_BIT          : position of each framing bit within the frame
//   - odd_parity_ok  : true when data plus parity bit holds an odd number of ones
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int START_BIT      = 0;
    localparam int PARITY_BIT     = 9;
    localparam int STOP_BIT       = 10;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo
//   Synchronous FIFO.
//   - DEPTH must be a power of two, at least 2.
//   - A push while full is accepted only when a pop happens in the same cycle.
//   - The head output is combinational from the storage and pointers, and it
//     reads 0 when the FIFO is empty.
// Ports:
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   push, wdata     : write request and data
//   pop             : read request (ignored when empty)
//   full, empty     : status
//   head            : entry at the read pointer, 0 when empty
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates the full case from the empty case.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             pop_ok, push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // When the FIFO is full, a simultaneous pop frees the slot that the write lands in.
    // The head value was already read before the clock edge.
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   Receives PS/2 keyboard frames.
//   - Checks the start bit, odd parity and the stop bit of each frame.
//   - Queues good scan codes in a FIFO with a ready/valid interface.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   ps2_clk      : raw PS/2 clock pin (asynchronous)
//   ps2_data     : raw PS/2 data pin (asynchronous)
//   ready_i      : consumer takes data_o this cycle
//   clr_i        : clears overflow_o
//   data_o       : scan code at the FIFO head, 0 when empty
//   valid_o      : FIFO non-empty
//   frame_err_o  : one-cycle pulse when a frame is rejected
//   overflow_o   : sticky flag; a good frame was dropped because the FIFO was full
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ready_i,
    input  logic       clr_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overflow_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronizers reset to the PS/2 idle level, so reset never creates a fall.
    logic [1:0] clk_sync, data_sync;
    logic       clk_prev, fall;
    logic       data_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            // Registered, so fall is high three clk cycles after the pin edge.
            fall      <= clk_prev & ~clk_sync[1];
        end
    end

    assign data_s = data_sync[1];

    // Receiver state
    rx_state_e     state, state_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          par, par_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic          frame_err_q, err_d;
    logic          push_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            to_cnt      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            shreg       <= shreg_d;
            par         <= par_d;
            to_cnt      <= to_cnt_d;
            frame_err_q <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        par_d     = par;
        err_d     = 1'b0;
        push_req  = 1'b0;

        // The gap counter runs only while a frame is in progress.
        if (fall)               to_cnt_d = '0;
        else if (state == RECV) to_cnt_d = to_cnt + 1'b1;
        else                    to_cnt_d = '0;

        unique case (state)
            IDLE: begin
                // A fall with data high is line noise, not a start bit. Ignore it.
                if (fall && !data_s) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'(START_BIT + 1);
                    shreg_d   = '0;
                    par_d     = 1'b0;
                end
            end
            RECV: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == 4'(STOP_BIT)) begin
                        state_d = CHECK;
                        // Register the verdict now, so the error pulse falls in the CHECK cycle.
                        err_d   = ~(data_s & odd_parity_ok(shreg, par));
                    end else if (bit_cnt == 4'(PARITY_BIT)) begin
                        par_d = data_s;
                    end else begin
                        shreg_d = {data_s, shreg[7:1]};  // LSB first
                    end
                end else if (to_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                    // The keyboard stalled mid-frame. Drop the partial frame without a pulse.
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end
            end
            CHECK: begin
                push_req  = ~frame_err_q;
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // FIFO and the consumer interface
    logic full, empty, pop;

    assign valid_o     = ~empty;
    assign pop         = valid_o & ready_i;
    assign frame_err_o = frame_err_q;

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (shreg),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (data_o)
    );

    // A set wins over clr_i in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       overflow_o <= 1'b0;
        else if (push_req & full & ~pop)  overflow_o <= 1'b1;
        else if (clr_i)                   overflow_o <= 1'b0;
    end

endmodule
